pipe_stage_regs: RTL and testbench

//   Owns the D/E/M/W instruction and PC pipeline registers. These are the values the hazard

---
 rtl/pipe_stage_regs.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_regs.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs.sv
// D/E/M/W instruction, PC, valid and write-register pipeline registers with
// stall-driven bubble injection, plus saturating stall and wrapping retire counters.
module pipe_stage_regs #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      instrF,
  input  logic [31:0]      pcF,
  output logic             en_pc,
  output logic [31:0]      instrD,
  output logic [31:0]      instrE,
  output logic [31:0]      instrM,
  output logic [31:0]      instrW,
  output logic [31:0]      pcD,
  output logic [31:0]      pcE,
  output logic [31:0]      pcM,
  output logic [31:0]      pcW,
  output logic             validD,
  output logic             validE,
  output logic             validM,
  output logic             validW,
  output logic [4:0]       waE,
  output logic [4:0]       waM,
  output logic [4:0]       waW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  logic [31:0]      instrD_q, instrE_q, instrM_q, instrW_q;
  logic [31:0]      instrD_d, instrE_d, instrM_d, instrW_d;
  logic [31:0]      pcD_q, pcE_q, pcM_q, pcW_q;
  logic [31:0]      pcD_d, pcE_d, pcM_d, pcW_d;
  logic             validD_q, validE_q, validM_q, validW_q;
  logic             validD_d, validE_d, validM_d, validW_d;
  logic [4:0]       waE_q, waM_q, waW_q;
  logic [4:0]       waE_d, waM_d, waW_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] retireCnt_q, retireCnt_d;
  logic [4:0]       destD;

  // Instructions that do not write a register (sw, beq, jr, nop, ...) map to $0.
  always_comb begin
    destD = 5'd0;
    unique case (instrD_q[31:26])
      OP_RTYPE: begin
        if (instrD_q[5:0] == FN_ADDU || instrD_q[5:0] == FN_SUBU) begin
          destD = instrD_q[15:11];
        end
      end
      OP_ORI, OP_LUI, OP_LW: destD = instrD_q[20:16];
      OP_JAL:                destD = 5'd31;
      default:               destD = 5'd0;
    endcase
  end

  always_comb begin
    instrD_d    = instrF;
    pcD_d       = pcF;
    validD_d    = 1'b1;
    instrE_d    = instrD_q;
    pcE_d       = pcD_q;
    validE_d    = validD_q;
    waE_d       = destD;
    instrM_d    = instrE_q;
    pcM_d       = pcE_q;
    validM_d    = validE_q;
    waM_d       = waE_q;
    instrW_d    = instrM_q;
    pcW_d       = pcM_q;
    validW_d    = validM_q;
    waW_d       = waM_q;
    stallCnt_d  = stallCnt_q;
    retireCnt_d = retireCnt_q + {{(CNT_W-1){1'b0}}, validW_q};

    // A stall freezes D and drops a bubble into E while M and W keep draining.
    if (stall) begin
      instrD_d = instrD_q;
      pcD_d    = pcD_q;
      validD_d = validD_q;
      instrE_d = 32'h0;
      validE_d = 1'b0;
      waE_d    = 5'd0;
      if (stallCnt_q != {CNT_W{1'b1}}) begin
        stallCnt_d = stallCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instrD_q    <= 32'h0;
      instrE_q    <= 32'h0;
      instrM_q    <= 32'h0;
      instrW_q    <= 32'h0;
      pcD_q       <= PC_RESET;
      pcE_q       <= PC_RESET;
      pcM_q       <= PC_RESET;
      pcW_q       <= PC_RESET;
      validD_q    <= 1'b0;
      validE_q    <= 1'b0;
      validM_q    <= 1'b0;
      validW_q    <= 1'b0;
      waE_q       <= 5'd0;
      waM_q       <= 5'd0;
      waW_q       <= 5'd0;
      stallCnt_q  <= '0;
      retireCnt_q <= '0;
    end else begin
      instrD_q    <= instrD_d;
      instrE_q    <= instrE_d;
      instrM_q    <= instrM_d;
      instrW_q    <= instrW_d;
      pcD_q       <= pcD_d;
      pcE_q       <= pcE_d;
      pcM_q       <= pcM_d;
      pcW_q       <= pcW_d;
      validD_q    <= validD_d;
      validE_q    <= validE_d;
      validM_q    <= validM_d;
      validW_q    <= validW_d;
      waE_q       <= waE_d;
      waM_q       <= waM_d;
      waW_q       <= waW_d;
      stallCnt_q  <= stallCnt_d;
      retireCnt_q <= retireCnt_d;
    end
  end

  assign en_pc      = ~stall | ~reset;
  assign instrD     = instrD_q;
  assign instrE     = instrE_q;
  assign instrM     = instrM_q;
  assign instrW     = instrW_q;
  assign pcD        = pcD_q;
  assign pcE        = pcE_q;
  assign pcM        = pcM_q;
  assign pcW        = pcW_q;
  assign validD     = validD_q;
  assign validE     = validE_q;
  assign validM     = validM_q;
  assign validW     = validW_q;
  assign waE        = waE_q;
  assign waM        = waM_q;
  assign waW        = waW_q;
  assign stall_cnt  = stallCnt_q;
  assign retire_cnt = retireCnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, flow-through, stalls, dest decode,
// reset during stall and stall counter saturation.
module tb_pipe_stage_regs;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] ORI1    = 32'h3401_0005;
  localparam logic [31:0] ORI4    = 32'h3404_0007;
  localparam logic [31:0] ORI5    = 32'h3405_000A;
  localparam logic [31:0] LW2     = 32'h8C02_0000;
  localparam logic [31:0] ADDU3   = 32'h0042_1821;
  localparam logic [31:0] SUBU7   = 32'h0021_3823;
  localparam logic [31:0] SW2     = 32'hAC02_0000;
  localparam logic [31:0] LUI9    = 32'h3C09_0001;
  localparam logic [31:0] JR31    = 32'h03E0_0008;
  localparam logic [31:0] JAL     = 32'h0C00_0100;
  localparam logic [31:0] PCRST   = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] instrF, pcF;
  logic        en_pc;
  logic [31:0] instrD, instrE, instrM, instrW;
  logic [31:0] pcD, pcE, pcM, pcW;
  logic        validD, validE, validM, validW;
  logic [4:0]  waE, waM, waW;
  logic [15:0] stall_cnt, retire_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_regs #(.PC_RESET(32'h0000_3000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .instrF(instrF), .pcF(pcF),
    .en_pc(en_pc),
    .instrD(instrD), .instrE(instrE), .instrM(instrM), .instrW(instrW),
    .pcD(pcD), .pcE(pcE), .pcM(pcM), .pcW(pcW),
    .validD(validD), .validE(validE), .validM(validM), .validW(validW),
    .waE(waE), .waM(waM), .waW(waW),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and return 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic [31:0] ins,
                               input logic [31:0] pc);
    reset  = rst;
    stall  = st;
    instrF = ins;
    pcF    = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b1; instrF = NOP; pcF = 32'h0;
    #1;
    checkOutput("en_pc forced during reset", 32'(en_pc), 32'd1);
    applyStimulus(1'b0, 1'b1, ORI1, 32'h50);
    applyStimulus(1'b0, 1'b1, ORI1, 32'h54);
    checkOutput("rst instrD", instrD, NOP);
    checkOutput("rst instrW", instrW, NOP);
    checkOutput("rst pcD", pcD, PCRST);
    checkOutput("rst pcE", pcE, PCRST);
    checkOutput("rst pcW", pcW, PCRST);
    checkOutput("rst valids", {28'd0, validD, validE, validM, validW}, 32'd0);
    checkOutput("rst wa", {17'd0, waE, waM, waW}, 32'd0);
    checkOutput("rst stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst retire_cnt", 32'(retire_cnt), 32'd0);

    // ori then four nops flowing without stalls
    applyStimulus(1'b1, 1'b0, ORI1, 32'h100);
    checkOutput("flow instrD", instrD, ORI1);
    checkOutput("flow validD", 32'(validD), 32'd1);
    applyStimulus(1'b1, 1'b0, NOP, 32'h104);
    checkOutput("flow waE ori", 32'(waE), 32'd1);
    applyStimulus(1'b1, 1'b0, NOP, 32'h108);
    applyStimulus(1'b1, 1'b0, NOP, 32'h10C);
    checkOutput("flow instrW", instrW, ORI1);
    checkOutput("flow pcW", pcW, 32'h100);
    checkOutput("flow waW", 32'(waW), 32'd1);
    checkOutput("flow retire before", 32'(retire_cnt), 32'd0);
    applyStimulus(1'b1, 1'b0, NOP, 32'h110);
    checkOutput("flow retire after", 32'(retire_cnt), 32'd1);

    // load-use: lw in E, addu in D, one stall
    applyStimulus(1'b1, 1'b0, LW2, 32'h200);
    applyStimulus(1'b1, 1'b0, ADDU3, 32'h204);
    checkOutput("lu waE lw", 32'(waE), 32'd2);
    reset = 1'b1; stall = 1'b1; instrF = ORI4; pcF = 32'h208;
    #1;
    checkOutput("lu en_pc", 32'(en_pc), 32'd0);
    applyStimulus(1'b1, 1'b1, ORI4, 32'h208);
    checkOutput("lu instrD hold", instrD, ADDU3);
    checkOutput("lu pcD hold", pcD, 32'h204);
    checkOutput("lu instrE bubble", instrE, NOP);
    checkOutput("lu validE", 32'(validE), 32'd0);
    checkOutput("lu pcE", pcE, 32'h204);
    checkOutput("lu waE", 32'(waE), 32'd0);
    checkOutput("lu instrM", instrM, LW2);
    checkOutput("lu waM", 32'(waM), 32'd2);
    checkOutput("lu stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("lu retire_cnt", 32'(retire_cnt), 32'd4);
    applyStimulus(1'b1, 1'b0, ORI4, 32'h208);
    checkOutput("lu release instrE", instrE, ADDU3);
    checkOutput("lu release waE", 32'(waE), 32'd3);
    checkOutput("lu release validM", 32'(validM), 32'd0);
    checkOutput("lu release instrW", instrW, LW2);

    // three consecutive stalls
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1; stall = 1'b1; instrF = ORI5; pcF = 32'h20C;
      #1;
      checkOutput("st3 en_pc low", 32'(en_pc), 32'd0);
      applyStimulus(1'b1, 1'b1, ORI5, 32'h20C);
      checkOutput("st3 instrD const", instrD, ORI4);
      checkOutput("st3 validE", 32'(validE), 32'd0);
    end
    checkOutput("st3 pcD const", pcD, 32'h208);
    checkOutput("st3 validM", 32'(validM), 32'd0);
    checkOutput("st3 validW", 32'(validW), 32'd0);
    checkOutput("st3 stall_cnt", 32'(stall_cnt), 32'd4);
    checkOutput("st3 retire_cnt", 32'(retire_cnt), 32'd7);
    reset = 1'b1; stall = 1'b0; instrF = ORI5; pcF = 32'h20C;
    #1;
    checkOutput("st3 en_pc back", 32'(en_pc), 32'd1);
    applyStimulus(1'b1, 1'b0, ORI5, 32'h20C);
    checkOutput("st3 waE ori4", 32'(waE), 32'd4);
    checkOutput("st3 validM b3", 32'(validM), 32'd0);
    applyStimulus(1'b1, 1'b0, NOP, 32'h210);
    checkOutput("st3 validW b3", 32'(validW), 32'd0);
    checkOutput("st3 instrM", instrM, ORI4);
    applyStimulus(1'b1, 1'b0, NOP, 32'h214);
    checkOutput("st3 instrW", instrW, ORI4);
    checkOutput("st3 waW", 32'(waW), 32'd4);
    checkOutput("st3 retire hold", 32'(retire_cnt), 32'd7);
    checkOutput("st3 stall_cnt kept", 32'(stall_cnt), 32'd4);

    // destination decode
    applyStimulus(1'b1, 1'b0, SUBU7, 32'h218);
    applyStimulus(1'b1, 1'b0, SW2, 32'h21C);
    checkOutput("dest subu", 32'(waE), 32'd7);
    applyStimulus(1'b1, 1'b0, LUI9, 32'h220);
    checkOutput("dest sw", 32'(waE), 32'd0);
    applyStimulus(1'b1, 1'b0, JR31, 32'h224);
    checkOutput("dest lui", 32'(waE), 32'd9);
    applyStimulus(1'b1, 1'b0, NOP, 32'h228);
    checkOutput("dest jr", 32'(waE), 32'd0);

    // reset during a stall with jal in E
    applyStimulus(1'b0, 1'b0, NOP, 32'h0);
    applyStimulus(1'b1, 1'b0, JAL, 32'h300);
    applyStimulus(1'b1, 1'b0, NOP, 32'h304);
    checkOutput("jal waE", 32'(waE), 32'd31);
    checkOutput("jal validE", 32'(validE), 32'd1);
    reset = 1'b0; stall = 1'b1; instrF = NOP; pcF = 32'h308;
    #1;
    checkOutput("rs en_pc", 32'(en_pc), 32'd1);
    applyStimulus(1'b0, 1'b1, NOP, 32'h308);
    checkOutput("rs instrE", instrE, NOP);
    checkOutput("rs instrD", instrD, NOP);
    checkOutput("rs pcD", pcD, PCRST);
    checkOutput("rs pcM", pcM, PCRST);
    checkOutput("rs valids", {28'd0, validD, validE, validM, validW}, 32'd0);
    checkOutput("rs waM", 32'(waM), 32'd0);
    checkOutput("rs waE", 32'(waE), 32'd0);
    checkOutput("rs stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rs retire_cnt", 32'(retire_cnt), 32'd0);

    // stall counter saturation, stalling with validD==0
    for (int i = 0; i < 65534; i++) begin
      applyStimulus(1'b1, 1'b1, NOP, 32'h400);
    end
    checkOutput("sat FFFE", 32'(stall_cnt), 32'h0000_FFFE);
    checkOutput("sat validD", 32'(validD), 32'd0);
    applyStimulus(1'b1, 1'b1, NOP, 32'h400);
    checkOutput("sat FFFF", 32'(stall_cnt), 32'h0000_FFFF);
    applyStimulus(1'b1, 1'b1, NOP, 32'h400);
    checkOutput("sat hold", 32'(stall_cnt), 32'h0000_FFFF);
    checkOutput("sat retire", 32'(retire_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
